// File: rtl/shift_pkg.sv
// Shared types and helpers for the word serializer.
package shift_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  // Beat counter width; at least one bit so M=1 still has a legal vector.
  function automatic int unsigned cnt_w(input int unsigned m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Beat counter with synchronous clear/load/increment and a terminal-count flag.
module mod_counter #(
  parameter int unsigned W   = 1,
  parameter int unsigned MAX = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= (cnt == MaxVal) ? '0 : cnt + W'(1);
    end
  end

  assign tc = (cnt == MaxVal);

endmodule

// File: rtl/word_serializer.sv
// Parallel-in, serial-out: emits an N*M-bit word as M N-bit beats, MS chunk first.
module word_serializer
  import shift_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N*M-1:0] din,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic [N-1:0] sout,
  output logic         sout_last
);

  localparam int unsigned W  = N * M;
  localparam int unsigned CW = cnt_w(M);
  localparam logic [CW-1:0] LastCnt = CW'(M - 1);

  ser_state_t    state;
  logic [W-1:0]  word_q;
  logic [CW-1:0] beat_cnt;
  logic          beat_tc;
  logic          load_xfer;
  logic          beat_xfer;

  assign sout_valid = (state == SHIFT);
  assign sout       = word_q[W-1 -: N];
  assign sout_last  = sout_valid & (beat_cnt == LastCnt);

  // Combinational sout_ready -> load_ready lets a new word follow the last beat directly.
  assign load_ready = (state == IDLE) | (sout_last & sout_ready);
  assign load_xfer  = load_valid & load_ready;
  assign beat_xfer  = sout_valid & sout_ready;

  mod_counter #(
    .W   (CW),
    .MAX (M - 1)
  ) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (load_xfer),
    .load     (1'b0),
    .load_val ('0),
    .inc      (beat_xfer & ~beat_tc),
    .cnt      (beat_cnt),
    .tc       (beat_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      word_q <= '0;
    end else if (load_xfer) begin
      word_q <= din;
      state  <= SHIFT;
    end else if (beat_xfer) begin
      if (!beat_tc) begin
        word_q <= word_q << N;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
